// File: rtl/mmio_pkg.sv
// Shared memory-bus definitions: command encodings and the I/O address map
// used by the CPU, the RAM decode and the MMIO responder.
package mmio_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [8:0] ADDR_LED    = 9'h100;
  localparam logic [8:0] ADDR_SW     = 9'h140;
  localparam logic [8:0] ADDR_TCOUNT = 9'h141;
  localparam logic [8:0] ADDR_TSTAT  = 9'h142;

  localparam int SW_W  = 10;
  localparam int LED_W = 8;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled countdown timer: running whenever count is nonzero, with a sticky
// done flag raised on the 1 -> 0 decrement.
module mmio_timer #(
  parameter int PRESCALE = 50000,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              clr,
  output logic [DATA_W-1:0] count,
  output logic              done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          expire;

  // A load on the same edge pre-empts the scheduled decrement and its done.
  assign tick   = (count != '0) && (pre_cnt == PRE_LAST);
  assign expire = !load && tick && (count == DATA_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      pre_cnt <= '0;
    end else if (load) begin
      count   <= load_val;
      pre_cnt <= '0;
    end else if (count != '0) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        count   <= count - DATA_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  // Setting done takes priority over a clear arriving on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else if (expire) begin
      done <= 1'b1;
    end else if (clr) begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target on the CPU memory bus: switch input, LED register and a
// countdown timer, answering mapped reads with a one-cycle registered response.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [SW_W-1:0]   sw_in,
  output logic [DATA_W-1:0] read_data,
  output logic              io_sel,
  output logic [LED_W-1:0]  led_out,
  output logic              timer_irq
);

  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [LED_W-1:0]  led;
  logic              is_read;
  logic              is_write;
  logic              hit_sw;
  logic              hit_led;
  logic              hit_tcount;
  logic              hit_tstat;
  logic              mapped;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] t_count;
  logic              t_done;
  logic              t_load;
  logic              t_clr;

  assign is_read    = (mem_cmd == MREAD);
  assign is_write   = (mem_cmd == MWRITE);
  assign hit_sw     = (mem_addr == ADDR_W'(ADDR_SW));
  assign hit_led    = (mem_addr == ADDR_W'(ADDR_LED));
  assign hit_tcount = (mem_addr == ADDR_W'(ADDR_TCOUNT));
  assign hit_tstat  = (mem_addr == ADDR_W'(ADDR_TSTAT));
  assign mapped     = hit_sw || hit_led || hit_tcount || hit_tstat;

  assign t_load = is_write && hit_tcount;
  assign t_clr  = is_write && hit_tstat && write_data[0];

  always_comb begin
    rd_val = '0;
    if (hit_sw) begin
      rd_val = DATA_W'(sw_sync);
    end else if (hit_led) begin
      rd_val = DATA_W'(led);
    end else if (hit_tcount) begin
      rd_val = t_count;
    end else if (hit_tstat) begin
      rd_val = DATA_W'(t_done);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= '0;
    end else if (is_write && hit_led) begin
      led <= write_data[LED_W-1:0];
    end
  end

  // The response is held across idle cycles so the top-level mux stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= '0;
      io_sel    <= 1'b0;
    end else if (is_read && mapped) begin
      read_data <= rd_val;
      io_sel    <= 1'b1;
    end else if (is_read || is_write) begin
      io_sel    <= 1'b0;
    end
  end

  mmio_timer #(
    .PRESCALE (PRESCALE),
    .DATA_W   (DATA_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (write_data),
    .clr      (t_clr),
    .count    (t_count),
    .done     (t_done)
  );

  assign led_out   = led;
  assign timer_irq = t_done;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: two instances (PRESCALE 4 and 1) on a shared bus,
// checked every cycle against a cycles-to-next-tick reference model.
module tb_mmio_responder;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [9:0]  sw_in;

  logic [15:0] rd4, rd1;
  logic        io4, io1;
  logic [7:0]  led4, led1;
  logic        irq4, irq1;

  logic [15:0] a_rd  [2];
  logic        a_io  [2];
  logic [7:0]  a_led [2];
  logic        a_irq [2];

  int checks = 0;
  int errors = 0;

  int          p_of    [2];
  logic [15:0] m_count [2];
  int          m_left  [2];
  logic        m_done  [2];
  logic [15:0] m_rd    [2];
  logic        m_io    [2];
  logic [7:0]  m_led;
  logic [9:0]  m_sw1, m_sw2;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_io;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  mmio_responder #(.PRESCALE(4), .ADDR_W(9), .DATA_W(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .sw_in(sw_in), .read_data(rd4), .io_sel(io4),
    .led_out(led4), .timer_irq(irq4)
  );

  mmio_responder #(.PRESCALE(1), .ADDR_W(9), .DATA_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .sw_in(sw_in), .read_data(rd1), .io_sel(io1),
    .led_out(led1), .timer_irq(irq1)
  );

  assign a_rd[0]  = rd4;
  assign a_rd[1]  = rd1;
  assign a_io[0]  = io4;
  assign a_io[1]  = io1;
  assign a_led[0] = led4;
  assign a_led[1] = led1;
  assign a_irq[0] = irq4;
  assign a_irq[1] = irq1;

  task automatic cmp(input string name, input int i, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d got %h expected %h at %0t", name, i, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = '0;
      m_left[i]  = p_of[i];
      m_done[i]  = 1'b0;
      m_rd[i]    = '0;
      m_io[i]    = 1'b0;
    end
    m_led = '0;
    m_sw1 = '0;
    m_sw2 = '0;
  endtask

  // Applies the bus rules to the pre-edge state using the inputs now driven.
  task automatic model_step();
    logic [15:0] val;
    logic        mapped;
    logic        set;
    logic        rdc;
    logic        wr;
    rdc = (mem_cmd == C_READ);
    wr  = (mem_cmd == C_WRITE);
    for (int i = 0; i < 2; i++) begin
      mapped = 1'b1;
      case (mem_addr)
        9'h140:  val = {6'b0, m_sw2};
        9'h100:  val = {8'b0, m_led};
        9'h141:  val = m_count[i];
        9'h142:  val = {15'b0, m_done[i]};
        default: begin val = '0; mapped = 1'b0; end
      endcase
      if (rdc) begin
        if (mapped) begin
          m_rd[i] = val;
          m_io[i] = 1'b1;
        end else begin
          m_io[i] = 1'b0;
        end
      end else if (wr) begin
        m_io[i] = 1'b0;
      end
      set = 1'b0;
      if (wr && mem_addr == 9'h141) begin
        m_count[i] = write_data;
        m_left[i]  = p_of[i];
      end else if (m_count[i] != 0) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_count[i] = m_count[i] - 16'd1;
          m_left[i]  = p_of[i];
          set = (m_count[i] == 0);
        end
      end
      if (set) m_done[i] = 1'b1;
      else if (wr && mem_addr == 9'h142 && write_data[0]) m_done[i] = 1'b0;
    end
    if (wr && mem_addr == 9'h100) m_led = write_data[7:0];
    m_sw2 = m_sw1;
    m_sw1 = sw_in;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      cmp("read_data", i, a_rd[i], m_rd[i]);
      cmp("io_sel", i, {15'b0, a_io[i]}, {15'b0, m_io[i]});
      cmp("led_out", i, {8'b0, a_led[i]}, {8'b0, m_led});
      cmp("timer_irq", i, {15'b0, a_irq[i]}, {15'b0, m_done[i]});
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                               input logic [15:0] wd);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    model_step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      cmp({name, "_rd"}, i, a_rd[i], 16'h0000);
      cmp({name, "_io"}, i, {15'b0, a_io[i]}, 16'h0000);
      cmp({name, "_led"}, i, {8'b0, a_led[i]}, 16'h0000);
      cmp({name, "_irq"}, i, {15'b0, a_irq[i]}, 16'h0000);
    end
  endtask

  initial begin
    logic [1:0]  r_cmd;
    logic [8:0]  r_addr;
    logic [15:0] r_wd;

    p_of[0] = 4;
    p_of[1] = 1;

    vecs[0]  = '{C_READ,  9'h140, 16'h0000, 16'h02A5, 1'b1, 8'h00};
    vecs[1]  = '{C_NONE,  9'h000, 16'h0000, 16'h02A5, 1'b1, 8'h00};
    vecs[2]  = '{C_WRITE, 9'h100, 16'hFF3C, 16'h02A5, 1'b0, 8'h3C};
    vecs[3]  = '{C_READ,  9'h100, 16'h0000, 16'h003C, 1'b1, 8'h3C};
    vecs[4]  = '{C_WRITE, 9'h140, 16'h1234, 16'h003C, 1'b0, 8'h3C};
    vecs[5]  = '{C_READ,  9'h140, 16'h0000, 16'h02A5, 1'b1, 8'h3C};
    vecs[6]  = '{C_READ,  9'h019, 16'h0000, 16'h02A5, 1'b0, 8'h3C};
    vecs[7]  = '{C_RSVD,  9'h100, 16'h0055, 16'h02A5, 1'b0, 8'h3C};
    vecs[8]  = '{C_READ,  9'h100, 16'h0000, 16'h003C, 1'b1, 8'h3C};
    vecs[9]  = '{C_RSVD,  9'h100, 16'h00AA, 16'h003C, 1'b1, 8'h3C};
    vecs[10] = '{C_WRITE, 9'h142, 16'h0001, 16'h003C, 1'b0, 8'h3C};

    reset_n    = 1'b0;
    mem_cmd    = C_NONE;
    mem_addr   = '0;
    write_data = '0;
    sw_in      = 10'h2A5;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 3; k++) applyStimulus(C_NONE, 9'h000, 16'h0000);

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].cmd, vecs[v].addr, vecs[v].wd);
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("vec%0d_rd", v), i, a_rd[i], vecs[v].exp_rd);
        cmp($sformatf("vec%0d_io", v), i, {15'b0, a_io[i]}, {15'b0, vecs[v].exp_io});
        cmp($sformatf("vec%0d_led", v), i, {8'b0, a_led[i]}, {8'b0, vecs[v].exp_led});
      end
    end

    // Countdown of 3 on the prescale-4 instance: done lands 12 cycles later.
    applyStimulus(C_WRITE, 9'h141, 16'd3);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus((k == 6 || k == 10) ? C_READ : C_NONE, 9'h141, 16'h0000);
      if (k == 6)  cmp("t3_read_mid", 0, rd4, 16'd2);
      if (k == 10) cmp("t3_read_late", 0, rd4, 16'd1);
      cmp("t3_irq", 0, {15'b0, irq4}, (k == 12) ? 16'd1 : 16'd0);
    end
    applyStimulus(C_WRITE, 9'h142, 16'h0001);
    cmp("t3_irq_clr", 0, {15'b0, irq4}, 16'd0);

    applyStimulus(C_WRITE, 9'h141, 16'd1);
    applyStimulus(C_WRITE, 9'h142, 16'h0001);
    cmp("clr_vs_set", 1, {15'b0, irq1}, 16'd1);
    applyStimulus(C_WRITE, 9'h142, 16'h0001);
    cmp("clr_after", 1, {15'b0, irq1}, 16'd0);
    applyStimulus(C_WRITE, 9'h141, 16'd3);
    applyStimulus(C_WRITE, 9'h141, 16'd5);
    applyStimulus(C_READ, 9'h141, 16'h0000);
    cmp("load_vs_dec", 1, rd1, 16'd5);

    applyStimulus(C_WRITE, 9'h141, 16'd100);
    for (int k = 0; k < 3; k++) applyStimulus(C_NONE, 9'h000, 16'h0000);
    applyStimulus(C_WRITE, 9'h141, 16'd0);
    for (int k = 0; k < 120; k++) applyStimulus(C_NONE, 9'h000, 16'h0000);
    applyStimulus(C_READ, 9'h141, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      cmp("stop_count", i, a_rd[i], 16'd0);
      cmp("stop_irq", i, {15'b0, a_irq[i]}, 16'd0);
    end

    // Asynchronous reset pulse in mid-cycle while both timers run.
    applyStimulus(C_WRITE, 9'h141, 16'd100);
    applyStimulus(C_WRITE, 9'h100, 16'h00AA);
    for (int k = 0; k < 5; k++) applyStimulus(C_NONE, 9'h000, 16'h0000);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 150; k++) applyStimulus(C_NONE, 9'h000, 16'h0000);
    applyStimulus(C_READ, 9'h141, 16'h0000);
    for (int i = 0; i < 2; i++) cmp("post_reset_count", i, a_rd[i], 16'd0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) sw_in = 10'($urandom);
      r_cmd = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: r_addr = 9'h140;
        1: r_addr = 9'h100;
        2: r_addr = 9'h141;
        3: r_addr = 9'h142;
        default: r_addr = 9'($urandom);
      endcase
      r_wd = (r_addr == 9'h141) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      applyStimulus(r_cmd, r_addr, r_wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
